// File: rtl/ex_div_unit_if.sv
// Request/response bundle for ex_div_unit: divide request in, quotient/remainder out.
interface ex_div_unit_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             div_by_zero;
  logic             busy;

  modport master (
    output in_valid, in_signed, x, y, flush, out_ready,
    input  in_ready, out_valid, quot, rem, div_by_zero, busy
  );

  modport slave (
    input  in_valid, in_signed, x, y, flush, out_ready,
    output in_ready, out_valid, quot, rem, div_by_zero, busy
  );
endinterface

// File: rtl/ex_div_unit.sv
// Iterative restoring divider, one quotient bit per clock, signed/unsigned,
// fixed WIDTH-cycle latency, divide-by-zero shortcut and flush abort.
module ex_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  ex_div_unit_if.slave dv
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_q, acc_r, dvsr, last_q, last_r;
  logic             neg_q, neg_r, dbz, out_valid_q, busy_q;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] x_mag, y_mag, res_q, res_r;
  logic             accept, deliver;

  always_comb begin
    x_mag = (dv.in_signed && dv.x[WIDTH-1]) ? -dv.x : dv.x;
    y_mag = (dv.in_signed && dv.y[WIDTH-1]) ? -dv.y : dv.y;
    // partial remainder stays below the divisor, so one extra bit covers the shift
    trial = {acc_r, acc_q[WIDTH-1]} - {1'b0, dvsr};
    res_q = neg_q ? -acc_q : acc_q;
    res_r = neg_r ? -acc_r : acc_r;
  end

  assign accept  = dv.in_valid & dv.in_ready & ~dv.flush;
  assign deliver = out_valid_q & dv.out_ready;

  assign dv.in_ready    = (state == IDLE) & ~reset;
  assign dv.out_valid   = out_valid_q;
  assign dv.busy        = busy_q;
  // idle shows the last delivered result; a flushed result never gets there
  assign dv.quot        = out_valid_q ? res_q : last_q;
  assign dv.rem         = out_valid_q ? res_r : last_r;
  assign dv.div_by_zero = out_valid_q & dbz;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      acc_q       <= '0;
      acc_r       <= '0;
      dvsr        <= '0;
      last_q      <= '0;
      last_r      <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz         <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (dv.flush) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          busy_q <= 1'b1;
          if (dv.y == '0) begin
            acc_q       <= '1;
            acc_r       <= dv.x;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dbz         <= 1'b1;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            acc_q <= x_mag;
            acc_r <= '0;
            dvsr  <= y_mag;
            neg_q <= dv.in_signed & (dv.x[WIDTH-1] ^ dv.y[WIDTH-1]);
            neg_r <= dv.in_signed & dv.x[WIDTH-1];
            dbz   <= 1'b0;
            cnt   <= CW'(WIDTH - 1);
            state <= CALC;
          end
        end
        CALC: begin
          acc_q <= {acc_q[WIDTH-2:0], ~trial[WIDTH]};
          acc_r <= trial[WIDTH] ? {acc_r[WIDTH-2:0], acc_q[WIDTH-1]} : trial[WIDTH-1:0];
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: if (deliver) begin
          last_q      <= res_q;
          last_r      <= res_r;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_div_unit.sv
// Directed + random bench for ex_div_unit at WIDTH=32 and WIDTH=8 against an arithmetic model.
module tb_ex_div_unit;
  logic clk = 1'b0;
  logic rst32, rst8;
  int   errs = 0, checks = 0;

  always #5 clk = ~clk;

  ex_div_unit_if #(.WIDTH(32)) b32();
  ex_div_unit_if #(.WIDTH(8))  b8();

  ex_div_unit #(.WIDTH(32)) u32 (.clk(clk), .reset(rst32), .dv(b32.slave));
  ex_div_unit #(.WIDTH(8))  u8  (.clk(clk), .reset(rst8),  .dv(b8.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // truncating division on sign/zero-extended 64-bit values; caller keeps the low bits
  task automatic model(input logic [63:0] x, input logic [63:0] y, input int w, input bit s,
                       output logic [63:0] q, output logic [63:0] r);
    longint xe, ye;
    xe = s ? longint'(x << (64 - w)) >>> (64 - w) : longint'(x);
    ye = s ? longint'(y << (64 - w)) >>> (64 - w) : longint'(y);
    if (ye == 0) begin
      q = '1;
      r = x;
    end else begin
      q = 64'(xe / ye);
      r = 64'(xe % ye);
    end
  endtask

  task automatic run32(input logic [31:0] x, input logic [31:0] y, input bit s,
                       input int hold, input string tag);
    logic [63:0] eq, er;
    int lat;
    model({32'b0, x}, {32'b0, y}, 32, s, eq, er);
    lat = 0;
    while (!b32.in_ready && lat < 100) begin @(negedge clk); lat++; end
    chk({tag, ".ready"}, 64'(b32.in_ready), 64'd1);
    b32.x = x; b32.y = y; b32.in_signed = s; b32.in_valid = 1'b1;
    @(posedge clk);
    // keep in_valid high with junk operands: must not disturb the divide in flight
    lat = 0;
    @(negedge clk);
    while (!b32.out_valid && lat < 100) begin
      b32.x = $urandom; b32.y = $urandom; b32.in_signed = 1'($urandom);
      @(negedge clk); lat++;
    end
    chk({tag, ".lat"},  64'(lat), (y == 0) ? 64'd0 : 64'd32);
    chk({tag, ".quot"}, 64'(b32.quot), 64'(eq[31:0]));
    chk({tag, ".rem"},  64'(b32.rem),  64'(er[31:0]));
    chk({tag, ".dbz"},  64'(b32.div_by_zero), 64'(y == 0));
    chk({tag, ".busy"}, 64'(b32.busy), 64'd1);
    repeat (hold) begin
      @(negedge clk);
      chk({tag, ".hold_q"},  64'(b32.quot), 64'(eq[31:0]));
      chk({tag, ".hold_r"},  64'(b32.rem),  64'(er[31:0]));
      chk({tag, ".hold_v"},  64'(b32.out_valid), 64'd1);
      chk({tag, ".hold_rd"}, 64'(b32.in_ready), 64'd0);
    end
    b32.out_ready = 1'b1;
    @(negedge clk);
    b32.out_ready = 1'b0; b32.in_valid = 1'b0;
    chk({tag, ".post_v"},  64'(b32.out_valid), 64'd0);
    chk({tag, ".post_rd"}, 64'(b32.in_ready), 64'd1);
    chk({tag, ".post_q"},  64'(b32.quot), 64'(eq[31:0]));
  endtask

  initial begin
    bit seen;
    int lat;
    logic [31:0] rx, ry;
    rst32 = 1'b1; rst8 = 1'b1;
    b32.in_valid = 0; b32.in_signed = 0; b32.x = 0; b32.y = 0; b32.flush = 0; b32.out_ready = 0;
    b8.in_valid = 0;  b8.in_signed = 0;  b8.x = 0;  b8.y = 0;  b8.flush = 0;  b8.out_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst.ready", 64'(b32.in_ready), 64'd0);
    chk("rst.valid", 64'(b32.out_valid), 64'd0);
    chk("rst.quot",  64'(b32.quot), 64'd0);
    chk("rst.rem",   64'(b32.rem), 64'd0);
    chk("rst.busy",  64'(b32.busy), 64'd0);
    rst32 = 1'b0; rst8 = 1'b0;
    @(negedge clk);
    chk("rst.ready_after", 64'(b32.in_ready), 64'd1);

    run32(32'd100, 32'd7, 1'b0, 0, "u100_7");
    run32(-32'sd7, 32'd2, 1'b1, 0, "s-7_2");
    run32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "s_ovf");
    run32(32'h1234_5678, 32'd0, 1'b1, 0, "s_dz");
    run32(32'h1234_5678, 32'd0, 1'b0, 0, "u_dz");
    run32(32'hDEAD_BEEF, 32'h0000_0013, 1'b0, 5, "stall5");

    // flush ten cycles into CALC
    b32.x = 32'd1000000; b32.y = 32'd3; b32.in_signed = 1'b0; b32.in_valid = 1'b1;
    @(negedge clk);
    b32.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("fl.busy", 64'(b32.busy), 64'd1);
    b32.flush = 1'b1;
    @(negedge clk);
    b32.flush = 1'b0;
    chk("fl.valid", 64'(b32.out_valid), 64'd0);
    chk("fl.ready", 64'(b32.in_ready), 64'd1);
    chk("fl.busy0", 64'(b32.busy), 64'd0);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (b32.out_valid) seen = 1'b1; end
    chk("fl.no_valid", 64'(seen), 64'd0);
    run32(32'd9, 32'd3, 1'b0, 0, "fl_9_3");

    // flush together with out_ready in DONE: result is dropped, last delivered stays visible
    b32.x = 32'd50; b32.y = 32'd5; b32.in_signed = 1'b0; b32.in_valid = 1'b1;
    @(negedge clk);
    b32.in_valid = 1'b0;
    lat = 0;
    while (!b32.out_valid && lat < 100) begin @(negedge clk); lat++; end
    chk("fd.quot", 64'(b32.quot), 64'd10);
    b32.flush = 1'b1; b32.out_ready = 1'b1;
    @(negedge clk);
    b32.flush = 1'b0; b32.out_ready = 1'b0;
    chk("fd.valid", 64'(b32.out_valid), 64'd0);
    chk("fd.ready", 64'(b32.in_ready), 64'd1);
    chk("fd.last_q", 64'(b32.quot), 64'd3);

    for (int i = 0; i < 12; i++) begin
      rx = $urandom;
      ry = ($urandom_range(0, 5) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 20));
      run32(rx, ry, 1'($urandom), $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end

    // WIDTH=8: 200/3, then reset mid-CALC
    b8.x = 8'd200; b8.y = 8'd3; b8.in_signed = 1'b0; b8.in_valid = 1'b1;
    @(negedge clk);
    b8.in_valid = 1'b0;
    lat = 0;
    while (!b8.out_valid && lat < 100) begin @(negedge clk); lat++; end
    chk("w8.lat",  64'(lat), 64'd8);
    chk("w8.quot", 64'(b8.quot), 64'd66);
    chk("w8.rem",  64'(b8.rem), 64'd2);
    chk("w8.dbz",  64'(b8.div_by_zero), 64'd0);
    b8.out_ready = 1'b1;
    @(negedge clk);
    b8.out_ready = 1'b0;
    chk("w8.ready", 64'(b8.in_ready), 64'd1);
    b8.x = 8'd77; b8.y = 8'd5; b8.in_valid = 1'b1;
    @(negedge clk);
    b8.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("w8r.busy_pre", 64'(b8.busy), 64'd1);
    rst8 = 1'b1;
    @(negedge clk);
    chk("w8r.quot",  64'(b8.quot), 64'd0);
    chk("w8r.rem",   64'(b8.rem), 64'd0);
    chk("w8r.valid", 64'(b8.out_valid), 64'd0);
    chk("w8r.busy",  64'(b8.busy), 64'd0);
    chk("w8r.dbz",   64'(b8.div_by_zero), 64'd0);
    chk("w8r.ready", 64'(b8.in_ready), 64'd0);
    rst8 = 1'b0;
    @(negedge clk);
    chk("w8r.ready_after", 64'(b8.in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
